sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
Sequencer for the SHA-256 message schedule (W expansion) that drives the sigma0/sigma1 rotate datapath (ROTR7/18/SHR3, ROTR17/19/SHR10).
Accepts one 512-bit block as 16 x 32-bit words over a valid/ready stream.
Emits W[0..63] one word per cycle on a registered valid/ready output stream to the compression round engine.
Holds the 16-word sliding window internally.

Parameters:
WORD_W, 32, word width; fixed by SHA-256, other values unsupported.
NUM_ROUNDS, 64, words emitted per block; index counter width = 6.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: drop current block, return to LOAD
in_valid  input  1  input word valid
in_ready  output  1  block accepts input word
in_data  input  32  message word, big-endian word order W0 first
out_valid  output  1  out_data holds valid W[t]
out_ready  input  1  consumer accepts word
out_data  output  32  W[t]
out_idx  output  6  t of current out_data
out_last  output  1  high with out_valid when out_idx==63
busy  output  1  high whenever state==EXPAND or out_valid==1

Behaviour:
- Reset values (async on rst_n low):
  - state=LOAD, t=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - Window registers cleared to 0.
- slot_free = !out_valid || out_ready. The output register loads only when slot_free.
- State LOAD (t=0..15):
  - in_ready = slot_free.
  - On in_valid&&in_ready: window[t%16]<=in_data; out_data<=in_data; out_idx<=t; out_valid<=1; t++.
  - After accepting t=15, go to EXPAND with t=16.
- State EXPAND (t=16..63):
  - in_ready=0.
  - Each slot_free cycle: W = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32 with carries discarded.
  - Store W into window[t%16], load it into the output register with out_idx=t, then t++.
  - sigma0(x) = ROTR7(x)^ROTR18(x)^SHR3(x); sigma1(x) = ROTR17(x)^ROTR19(x)^SHR10(x).
  - Window addresses use t modulo 16 (4-bit wrap). W[t-16] is read from the slot being overwritten, so read happens before write in the same cycle.
  - After loading t=63, go to LOAD with t=0.
- Latency and throughput:
  - Input handshake to out_valid: 1 cycle.
  - 1 word/cycle with out_ready held high; 64 cycles per block minimum.
  - The next block's W0 can be accepted in the cycle W63 is consumed; no bubble.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable, and t and the window do not advance.
- out_last = out_valid && out_idx==63.
- clear (synchronous, highest priority below reset):
  - Sets state=LOAD, t=0, out_valid=0.
  - A simultaneous input or output handshake is discarded; window contents are don't-care.
- Reset mid-block: all partial progress lost. The first word after reset is treated as W0.
- in_valid during EXPAND is ignored (in_ready=0). Upstream must hold data per valid/ready rules.

Optional Feature:
MSG_SCHED_STATS_EN:
- When defined, adds outputs blk_count[31:0] and stall_count[31:0], both reset to 0 by rst_n only (not by clear).
- blk_count increments when the out_last handshake completes, wrapping at 2^32.
- stall_count increments every cycle with out_valid && !out_ready, saturating at 0xFFFFFFFF.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- "abc" padded block streamed (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1:
  - Outputs W16=0x61626380 and W17=0x000F0000.
  - All 64 words match the golden SHA-256 model; out_last only at idx 63; 64 consecutive out_valid cycles.
- All-zero block -> all 64 outputs 0x00000000, out_idx sequences 0..63, then in_ready high again.
- Backpressure: out_ready=0 for 5 cycles when out_idx==20 -> out_data and out_idx stable throughout; sequence resumes with idx 21 and matches the golden model.
- Back-to-back blocks with in_valid held high -> W0 of block 2 appears the cycle after W63 handshake, with no gap.
- clear asserted at idx 40, then rst_n pulsed low at idx 5 of the next block:
  - Each returns to LOAD with out_valid=0.
  - The next streamed block is emitted correctly from idx 0.
- With MSG_SCHED_STATS_EN: 3 blocks with 7 injected stall cycles -> blk_count=3, stall_count=7; clear leaves both unchanged.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule (W expansion) sequencer.
// Takes one 512-bit block as 16 x 32-bit words and emits W[0..63] one word
// per cycle on a registered output stream, keeping the last 16 words in a
// sliding window addressed by t mod 16.
// Optional statistics counters are enabled with `define MSG_SCHED_STATS_EN.
//
// Handshake rule (both streams): a word transfers on a rising edge where
// valid && ready are both high; a producer keeps valid and data stable until
// that edge, and ready may depend combinationally on the consumer side.
module sha256_msg_sched #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              busy
`ifdef MSG_SCHED_STATS_EN
  ,
  output logic [31:0]       blk_count,
  output logic [31:0]       stall_count
`endif
);

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic { LOAD, EXPAND } state_e;

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] LOAD_T = 6'd15;

  // Small sigma functions of the W expansion (32-bit word rotations).
  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        out_valid_q, out_valid_d;
  word_t       out_data_q, out_data_d;
  logic [5:0]  out_idx_q, out_idx_d;
  word_t       window_q [16];

  logic        slot_free;
  logic        win_we;
  word_t       win_wdata;
  logic [3:0]  a_t2, a_t7, a_t15, a_t16;
  word_t       w_new;

  // The output register may take a new word when empty or being drained.
  assign slot_free = !out_valid_q || out_ready;

  // Window taps relative to t; t-16 aliases the slot about to be written.
  assign a_t2  = t_q[3:0] - 4'd2;
  assign a_t7  = t_q[3:0] - 4'd7;
  assign a_t15 = t_q[3:0] + 4'd1;
  assign a_t16 = t_q[3:0];

  assign w_new = sig1(window_q[a_t2]) + window_q[a_t7]
               + sig0(window_q[a_t15]) + window_q[a_t16];

  assign in_ready  = (state_q == LOAD) && slot_free;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_valid_q && (out_idx_q == LAST_T);
  assign busy      = (state_q == EXPAND) || out_valid_q;

  // Next-state: load a word into the window and output register per slot.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    win_we      = 1'b0;
    win_wdata   = in_data;
    if (slot_free) begin
      out_valid_d = 1'b0;
    end
    if (clear) begin
      state_d     = LOAD;
      t_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid && slot_free) begin
            win_we      = 1'b1;
            win_wdata   = in_data;
            out_data_d  = in_data;
            out_idx_d   = t_q;
            out_valid_d = 1'b1;
            t_d         = t_q + 6'd1;
            if (t_q == LOAD_T) begin
              state_d = EXPAND;
            end
          end
        end
        EXPAND: begin
          if (slot_free) begin
            win_we      = 1'b1;
            win_wdata   = w_new;
            out_data_d  = w_new;
            out_idx_d   = t_q;
            out_valid_d = 1'b1;
            if (t_q == LAST_T) begin
              state_d = LOAD;
              t_d     = '0;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = LOAD;
          t_d     = '0;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Sliding window: one slot written per accepted/expanded word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= '0;
      end
    end else if (win_we) begin
      window_q[t_q[3:0]] <= win_wdata;
    end
  end

`ifdef MSG_SCHED_STATS_EN
  logic [31:0] blk_count_q, stall_count_q;

  // Block and stall counters; cleared only by rst_n, never by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (!clear && out_last && out_ready) begin
        blk_count_q <= blk_count_q + 32'd1;
      end
      if (out_valid_q && !out_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign blk_count   = blk_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: streams known blocks, compares every
// emitted word against an expected queue built from a reference expansion.
module tb_sha256_msg_sched;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;
`ifdef MSG_SCHED_STATS_EN
  logic [31:0] blk_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
`ifdef MSG_SCHED_STATS_EN
    ,
    .blk_count   (blk_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [5:0]  exp_idx_q[$];
  logic [31:0] in_q[$];
  logic [31:0] msg [16];
  logic [31:0] cap [64];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          gcyc     = 0;
  int          fire_count;
  int          first_fire;
  int          last_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference expansion ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [31:0] m [16]);
    logic [31:0] w [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        w[t] = m[t];
        in_q.push_back(m[t]);
      end else begin
        w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
      end
      exp_q.push_back(w[t]);
      exp_idx_q.push_back(6'(t));
    end
  endtask

  task automatic set_pattern(input logic [31:0] seed);
    for (int i = 0; i < 16; i++) begin
      msg[i] = (seed * 32'(i + 1)) ^ {seed[15:0], seed[31:16]};
    end
  endtask

  // ---------------- driver / monitor ----------------
  // Called at posedge+1. abort_kind: 0 none, 1 clear, 2 async reset.
  task automatic run(input int stall_idx, input int stall_len,
                     input int abort_idx, input int abort_kind, input int budget);
    int          cyc = 0;
    int          left = stall_len;
    bit          stalled = 0;
    bit          done = 0;
    logic [31:0] hold_d = '0;
    logic [5:0]  hold_i = '0;
    logic [31:0] e_d;
    logic [5:0]  e_i;
    fire_count = 0;
    first_fire = 0;
    last_fire  = 0;
    while (!done) begin
      in_valid  = (in_q.size() != 0);
      in_data   = in_valid ? in_q[0] : 32'h0;
      out_ready = 1'b1;
      clear     = 1'b0;
      if (abort_kind != 0 && out_valid && int'(out_idx) == abort_idx) begin
        if (abort_kind == 1) begin
          clear     = 1'b1;
          in_valid  = 1'b0;
          out_ready = 1'b0;
          @(posedge clk); #1;
          clear = 1'b0;
          check("clear_out_valid", {31'b0, out_valid}, 32'd0);
          check("clear_in_ready", {31'b0, in_ready}, 32'd1);
          check("clear_busy", {31'b0, busy}, 32'd0);
        end else begin
          rst_n = 1'b0;
          #1;
          check("rst_out_valid", {31'b0, out_valid}, 32'd0);
          check("rst_out_idx", {26'b0, out_idx}, 32'd0);
          check("rst_out_data", out_data, 32'd0);
          rst_n = 1'b1;
        end
        in_q.delete();
        exp_q.delete();
        exp_idx_q.delete();
        in_valid = 1'b0;
        return;
      end
      if (out_valid && int'(out_idx) == stall_idx && left > 0) begin
        out_ready = 1'b0;
        if (!stalled) begin
          hold_d  = out_data;
          hold_i  = out_idx;
          stalled = 1;
        end
        left--;
      end
      @(negedge clk);
      if (stalled && !out_ready) begin
        check("stall_data", out_data, hold_d);
        check("stall_idx", {26'b0, out_idx}, {26'b0, hold_i});
      end
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {31'b0, out_valid}, 32'd0);
        end else begin
          e_d = exp_q.pop_front();
          e_i = exp_idx_q.pop_front();
          check("out_data", out_data, e_d);
          check("out_idx", {26'b0, out_idx}, {26'b0, e_i});
          check("out_last", {31'b0, out_last}, {31'b0, (e_i == 6'd63)});
          cap[out_idx] = out_data;
          if (fire_count == 0) first_fire = gcyc;
          last_fire = gcyc;
          fire_count++;
        end
      end
      @(posedge clk); #1;
      gcyc++;
      cyc++;
      if (in_q.size() == 0 && exp_q.size() == 0) done = 1;
      if (!done && cyc >= budget) begin
        n_checks++;
        n_fail++;
        $error("FAIL run_timeout: observed %0d cycles expected completion", cyc);
        in_q.delete();
        exp_q.delete();
        exp_idx_q.delete();
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_idx", {26'b0, out_idx}, 32'd0);
    check("reset_out_last", {31'b0, out_last}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" padded block
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h6162_6380;
    msg[15] = 32'h0000_0018;
    push_block(msg);
    run(-1, 0, -1, 0, 400);
    check("abc_w16", cap[16], 32'h6162_6380);
    check("abc_w17", cap[17], 32'h000F_0000);
    check("abc_count", 32'(fire_count), 32'd64);
    check("abc_span", 32'(last_fire - first_fire), 32'd63);
    check("abc_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("abc_idle_busy", {31'b0, busy}, 32'd0);

    // all-zero block
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    push_block(msg);
    run(-1, 0, -1, 0, 400);
    check("zero_w63", cap[63], 32'h0);
    check("zero_count", 32'(fire_count), 32'd64);
    check("zero_in_ready", {31'b0, in_ready}, 32'd1);

    // backpressure: 5 stalled cycles at idx 20
    set_pattern(32'h9E37_79B9);
    push_block(msg);
    run(20, 5, -1, 0, 400);
    check("bp_count", 32'(fire_count), 32'd64);
    check("bp_span", 32'(last_fire - first_fire), 32'd68);

    // back-to-back blocks, no bubble between W63 and next W0
    set_pattern(32'h1234_5678);
    push_block(msg);
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h6162_6380;
    msg[15] = 32'h0000_0018;
    push_block(msg);
    run(-1, 0, -1, 0, 600);
    check("b2b_count", 32'(fire_count), 32'd128);
    check("b2b_span", 32'(last_fire - first_fire), 32'd127);

    // clear at idx 40, then reset at idx 5 of the next block
    set_pattern(32'hDEAD_BEEF);
    push_block(msg);
    run(-1, 0, 40, 1, 400);
    set_pattern(32'h0BAD_F00D);
    push_block(msg);
    run(-1, 0, 5, 2, 400);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // recovery block emitted from idx 0
    set_pattern(32'hCAFE_0123);
    push_block(msg);
    run(-1, 0, -1, 0, 400);
    check("recov_count", 32'(fire_count), 32'd64);
    check("recov_span", 32'(last_fire - first_fire), 32'd63);

`ifdef MSG_SCHED_STATS_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("stats_blk_reset", blk_count, 32'd0);
    check("stats_stall_reset", stall_count, 32'd0);
    for (int b = 0; b < 3; b++) begin
      set_pattern(32'h0101_0101 + 32'(b));
      push_block(msg);
    end
    run(30, 7, -1, 0, 900);
    check("stats_blk", blk_count, 32'd3);
    check("stats_stall", stall_count, 32'd7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    check("stats_blk_clear", blk_count, 32'd3);
    check("stats_stall_clear", stall_count, 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
